// File: rtl/code_search_ctrl_if.sv
// Bus between the channel register block / correlator and code_search_ctrl.
// master: software registers + correlator side; slave: the search sequencer.
interface code_search_ctrl_if #(
   parameter int BIN_W   = 11,
   parameter int DWELL_W = 8,
   parameter int MAG_W   = 24
);
   // Search set-up and control
   logic                       start;
   logic                       abort;
   logic [9:0]                 prn_key_in;
   logic [10:0]                step;
   logic [BIN_W-1:0]           num_bins;
   logic [DWELL_W-1:0]         dwell;
   logic [MAG_W+DWELL_W-1:0]   threshold;
   // Correlator dump results
   logic                       mag_valid;
   logic [MAG_W-1:0]           mag;
   // Code generator commands
   logic                       prn_key_enable;
   logic [9:0]                 prn_key;
   logic                       slew_enable;
   logic [10:0]                code_slew;
   // Status and result
   logic                       busy;
   logic                       done;
   logic                       hit;
   logic [BIN_W-1:0]           best_bin;
   logic [MAG_W+DWELL_W-1:0]   best_mag;

   modport master (
      output start, abort, prn_key_in, step, num_bins, dwell, threshold,
             mag_valid, mag,
      input  prn_key_enable, prn_key, slew_enable, code_slew,
             busy, done, hit, best_bin, best_mag
   );

   modport slave (
      input  start, abort, prn_key_in, step, num_bins, dwell, threshold,
             mag_valid, mag,
      output prn_key_enable, prn_key, slew_enable, code_slew,
             busy, done, hit, best_bin, best_mag
   );
endinterface

// File: rtl/code_search_ctrl.sv
// Acquisition code-phase search sequencer for one tracking channel.
// Loads the PRN key, then walks num_bins code-phase bins in half-chip slews,
// accumulating 'dwell' magnitudes per bin after two discarded dumps, and keeps
// the bin with the largest accumulated magnitude (ties keep the earlier bin).
// Optional feature macro: CODE_SEARCH_EARLY_EXIT_EN -- stop the search at the
// first bin whose accumulated magnitude exceeds threshold and raise hit.
module code_search_ctrl #(
   parameter int BIN_W   = 11,
   parameter int DWELL_W = 8,
   parameter int MAG_W   = 24
) (
   input logic               clk,
   input logic               rstn,
   code_search_ctrl_if.slave bus
);

   localparam int ACC_W = MAG_W + DWELL_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DISCARD,
      S_DWELL,
      S_EVAL,
      S_SLEW,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [9:0]           prn_key_q, prn_key_d;
   logic [10:0]          code_slew_q, code_slew_d;
   logic [BIN_W-1:0]     num_bins_q, num_bins_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [BIN_W-1:0]     bin_q, bin_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
   logic [1:0]           disc_q, disc_d;
   logic [BIN_W-1:0]     best_bin_q, best_bin_d;
   logic [ACC_W-1:0]     best_mag_q, best_mag_d;
   logic [BIN_W-1:0]     last_bin;

`ifdef CODE_SEARCH_EARLY_EXIT_EN
   logic                 hit_q, hit_d;
`else
   logic                 unused_threshold;
   assign unused_threshold = ^bus.threshold;
`endif

   assign last_bin = num_bins_q - BIN_W'(1);

   // Next-state and datapath updates; abort overrides every other transition
   always_comb begin
      state_d     = state_q;
      prn_key_d   = prn_key_q;
      code_slew_d = code_slew_q;
      num_bins_d  = num_bins_q;
      dwell_d     = dwell_q;
      bin_d       = bin_q;
      acc_d       = acc_q;
      dwell_cnt_d = dwell_cnt_q;
      disc_d      = disc_q;
      best_bin_d  = best_bin_q;
      best_mag_d  = best_mag_q;
`ifdef CODE_SEARCH_EARLY_EXIT_EN
      hit_d       = hit_q;
`endif

      if (bus.abort && (state_q != S_IDLE)) begin
         // Everything else freezes so best_bin/best_mag keep partial results
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  prn_key_d   = bus.prn_key_in;
                  code_slew_d = bus.step;
                  num_bins_d  = (bus.num_bins == '0) ? BIN_W'(1) : bus.num_bins;
                  dwell_d     = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                  bin_d       = '0;
                  acc_d       = '0;
                  dwell_cnt_d = '0;
                  best_bin_d  = '0;
                  best_mag_d  = '0;
`ifdef CODE_SEARCH_EARLY_EXIT_EN
                  hit_d       = 1'b0;
`endif
                  state_d     = S_LOAD;
               end
            end

            S_LOAD: begin
               disc_d  = 2'd2;
               state_d = S_DISCARD;
            end

            S_DISCARD: begin
               if (bus.mag_valid) begin
                  if (disc_q == 2'd1) begin
                     disc_d      = '0;
                     acc_d       = '0;
                     dwell_cnt_d = '0;
                     state_d     = S_DWELL;
                  end else begin
                     disc_d = disc_q - 2'd1;
                  end
               end
            end

            S_DWELL: begin
               if (bus.mag_valid) begin
                  acc_d       = acc_q + ACC_W'(bus.mag);
                  dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                  if (dwell_cnt_d == dwell_q) begin
                     state_d = S_EVAL;
                  end
               end
            end

            S_EVAL: begin
               if ((bin_q == '0) || (acc_q > best_mag_q)) begin
                  best_bin_d = bin_q;
                  best_mag_d = acc_q;
               end
               if (bin_q == last_bin) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SLEW;
               end
`ifdef CODE_SEARCH_EARLY_EXIT_EN
               // Threshold crossing wins over the normal best/next-bin choice
               if (acc_q > bus.threshold) begin
                  hit_d      = 1'b1;
                  best_bin_d = bin_q;
                  best_mag_d = acc_q;
                  state_d    = S_DONE;
               end
`endif
            end

            S_SLEW: begin
               bin_d   = bin_q + BIN_W'(1);
               disc_d  = 2'd2;
               state_d = S_DISCARD;
            end

            S_DONE: begin
               state_d = S_IDLE;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         prn_key_q   <= '0;
         code_slew_q <= '0;
         num_bins_q  <= '0;
         dwell_q     <= '0;
         bin_q       <= '0;
         acc_q       <= '0;
         dwell_cnt_q <= '0;
         disc_q      <= '0;
         best_bin_q  <= '0;
         best_mag_q  <= '0;
`ifdef CODE_SEARCH_EARLY_EXIT_EN
         hit_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         prn_key_q   <= prn_key_d;
         code_slew_q <= code_slew_d;
         num_bins_q  <= num_bins_d;
         dwell_q     <= dwell_d;
         bin_q       <= bin_d;
         acc_q       <= acc_d;
         dwell_cnt_q <= dwell_cnt_d;
         disc_q      <= disc_d;
         best_bin_q  <= best_bin_d;
         best_mag_q  <= best_mag_d;
`ifdef CODE_SEARCH_EARLY_EXIT_EN
         hit_q       <= hit_d;
`endif
      end
   end

   assign bus.prn_key_enable = (state_q == S_LOAD);
   assign bus.prn_key        = prn_key_q;
   assign bus.slew_enable    = (state_q == S_SLEW);
   assign bus.code_slew      = code_slew_q;
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.done           = (state_q == S_DONE);
   assign bus.best_bin       = best_bin_q;
   assign bus.best_mag       = best_mag_q;
`ifdef CODE_SEARCH_EARLY_EXIT_EN
   assign bus.hit            = hit_q;
`else
   assign bus.hit            = 1'b0;
`endif

endmodule

// File: tb/tb_code_search_ctrl.sv
// Self-checking bench for code_search_ctrl: table of search scenarios plus
// hand-written abort, start-while-busy, ignored-strobe and mid-search reset
// sequences. Expected results are queued at start and checked at done.
`timescale 1ns/1ps
module tb_code_search_ctrl;

   localparam int BIN_W   = 11;
   localparam int DWELL_W = 8;
   localparam int MAG_W   = 24;
   localparam int ACC_W   = MAG_W + DWELL_W;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   code_search_ctrl_if #(.BIN_W(BIN_W), .DWELL_W(DWELL_W), .MAG_W(MAG_W)) bus ();

   code_search_ctrl #(.BIN_W(BIN_W), .DWELL_W(DWELL_W), .MAG_W(MAG_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct packed {
      logic [10:0]              nb;
      logic [7:0]               dw;
      logic [10:0]              step;
      logic [9:0]               key;
      logic [31:0]              thr;
      logic [7:0][3:0][23:0]    mags;    // [bin][dump]
      logic [10:0]              exp_bin;
      logic [31:0]              exp_mag;
   } row_t;

   typedef struct {
      logic [10:0]  bin;
      logic [31:0]  mag;
      logic         hit;
      int unsigned  slews;
      int unsigned  strobes;
      int unsigned  pkes;
   } exp_t;

   row_t        rows [5];
   exp_t        exp_q [$];
   exp_t        mon_e;
   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned pke_total = 0;
   int unsigned slew_total = 0;
   int unsigned done_total = 0;
   int unsigned strobe_total = 0;
   logic [9:0]  cur_key = '0;
   logic [10:0] cur_step = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected hit / slew count / counted strobes for a table row
   function automatic void model(input row_t r, output logic hit,
                                 output int unsigned slews, output int unsigned strobes);
      int unsigned nb = (r.nb == 0) ? 1 : int'(r.nb);
      int unsigned dw = (r.dw == 0) ? 1 : int'(r.dw);
      int unsigned run = nb;
      hit = 1'b0;
`ifdef CODE_SEARCH_EARLY_EXIT_EN
      for (int unsigned b = 0; b < nb; b++) begin
         int unsigned sum = 0;
         for (int unsigned k = 0; k < dw; k++) sum += int'(r.mags[b][k]);
         if (sum > r.thr) begin
            hit = 1'b1;
            run = b + 1;
            break;
         end
      end
`endif
      slews   = run - 1;
      strobes = run * (dw + 2);
   endfunction

   // One strobe; counted strobes feed the consumed-strobe check
   task automatic strobe(input logic [23:0] m, input bit counted);
      bus.mag_valid = 1'b1;
      bus.mag       = m;
      if (counted) strobe_total++;
      cyc(1);
      bus.mag_valid = 1'b0;
      cyc(4);
   endtask

   task automatic drive_start(input row_t r);
      cur_key           = r.key;
      cur_step          = r.step;
      bus.prn_key_in    = r.key;
      bus.step          = r.step;
      bus.num_bins      = r.nb;
      bus.dwell         = r.dw;
      bus.threshold     = r.thr;
      bus.start         = 1'b1;
      cyc(1);
      bus.start         = 1'b0;
   endtask

   // Full search of one row; inject adds strobes in IDLE, LOAD, EVAL and SLEW/DONE
   task automatic run_row(input row_t r, input bit inject);
      exp_t e;
      logic h;
      int unsigned s, st, d0, nb, dw, waited;
      model(r, h, s, st);
      e.bin = r.exp_bin; e.mag = r.exp_mag; e.hit = h;
      e.slews = slew_total + s; e.strobes = strobe_total + st; e.pkes = pke_total + 1;
      nb = (r.nb == 0) ? 1 : int'(r.nb);
      dw = (r.dw == 0) ? 1 : int'(r.dw);
      d0 = done_total;
      if (inject) strobe(24'h00ABCD, 1'b0);
      exp_q.push_back(e);
      drive_start(r);
      if (inject) begin
         bus.mag_valid = 1'b1; bus.mag = 24'h0FF000;
         cyc(1);
         bus.mag_valid = 1'b0;
      end
      cyc(2);
      for (int unsigned b = 0; b < nb; b++) begin
         for (int unsigned k = 0; k < dw + 2; k++) begin
            if (done_total != d0) break;
            bus.mag_valid = 1'b1;
            bus.mag = (k < 2) ? 24'h700000 + 24'(b) : r.mags[b][k-2];
            strobe_total++;
            cyc(1);
            if (inject && (k == dw + 1)) begin
               bus.mag = 24'h0FFFFF;
               cyc(2);
            end
            bus.mag_valid = 1'b0;
            cyc(4);
         end
      end
      waited = 0;
      while ((done_total == d0) && (waited < 30)) begin
         cyc(1);
         waited++;
      end
      chk("done_seen", done_total - d0, 1);
      cyc(1);
      chk("busy_after_done", bus.busy, 0);
   endtask

   // Observe DUT pulses; compare queued expectations on each done
   always @(negedge clk) begin
      if (bus.prn_key_enable) begin
         pke_total++;
         chk("prn_key", bus.prn_key, cur_key);
      end
      if (bus.slew_enable) begin
         slew_total++;
         chk("code_slew", bus.code_slew, cur_step);
      end
      if (bus.done) begin
         done_total++;
         chk("done_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("best_bin", bus.best_bin, mon_e.bin);
            chk("best_mag", bus.best_mag, mon_e.mag);
            chk("hit", bus.hit, mon_e.hit);
            chk("busy_in_done", bus.busy, 1);
            chk("slew_count", slew_total, mon_e.slews);
            chk("strobe_count", strobe_total, mon_e.strobes);
            chk("prn_load_count", pke_total, mon_e.pkes);
         end
      end
   end

   initial begin : main
      row_t r;
      int unsigned p0, d0;

      bus.start = 0; bus.abort = 0; bus.prn_key_in = '0; bus.step = '0;
      bus.num_bins = '0; bus.dwell = '0; bus.threshold = '0;
      bus.mag_valid = 0; bus.mag = '0;

      // Table: nb, dw, step, key, thr, mags, expected best
      for (int i = 0; i < 5; i++) rows[i] = '0;
      rows[0].nb = 4; rows[0].dw = 2; rows[0].step = 2; rows[0].key = 10'h3A5; rows[0].thr = 60;
      rows[0].mags[0] = {24'd0, 24'd0, 24'd10, 24'd10};
      rows[0].mags[1] = {24'd0, 24'd0, 24'd40, 24'd50};
      rows[0].mags[2] = {24'd0, 24'd0, 24'd30, 24'd30};
      rows[0].mags[3] = {24'd0, 24'd0, 24'd5,  24'd5};
      rows[0].exp_bin = 1; rows[0].exp_mag = 90;
      rows[1].nb = 0; rows[1].dw = 0; rows[1].step = 5; rows[1].key = 10'h001; rows[1].thr = '1;
      rows[1].mags[0] = {24'd0, 24'd0, 24'd0, 24'd77};
      rows[1].exp_bin = 0; rows[1].exp_mag = 77;
      rows[2].nb = 2; rows[2].dw = 3; rows[2].step = 11'h7FF; rows[2].key = 10'h2C1; rows[2].thr = '1;
      rows[2].mags[0] = {24'd0, 24'd3, 24'd2, 24'd1};
      rows[2].mags[1] = {24'd0, 24'd1, 24'd2, 24'd3};
      rows[2].exp_bin = 0; rows[2].exp_mag = 6;
      rows[3].nb = 5; rows[3].dw = 1; rows[3].step = 1; rows[3].key = 10'h155; rows[3].thr = '1;
      rows[3].mags[0][0] = 4; rows[3].mags[1][0] = 3; rows[3].mags[2][0] = 9;
      rows[3].mags[3][0] = 2; rows[3].mags[4][0] = 10;
      rows[3].exp_bin = 4; rows[3].exp_mag = 10;
      rows[4].nb = 3; rows[4].dw = 4; rows[4].step = 3; rows[4].key = 10'h0F0; rows[4].thr = '1;
      rows[4].mags[0] = {24'd1, 24'd1, 24'd1, 24'd1};
      rows[4].mags[1] = {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
      rows[4].mags[2] = {24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
      rows[4].exp_bin = 1; rows[4].exp_mag = 32'h03FFFFFC;

      cyc(3);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_pke", bus.prn_key_enable, 0);
      chk("rst_slew", bus.slew_enable, 0);
      chk("rst_hit", bus.hit, 0);
      chk("rst_best_bin", bus.best_bin, 0);
      chk("rst_best_mag", bus.best_mag, 0);
      chk("rst_prn_key", bus.prn_key, 0);
      chk("rst_code_slew", bus.code_slew, 0);
      rstn = 1'b1;
      cyc(2);

      for (int i = 0; i < 5; i++) run_row(rows[i], 1'b0);

      // Strobes in IDLE, LOAD, EVAL, SLEW and DONE must not count
      run_row(rows[0], 1'b1);

      // Abort in DISCARD of bin 2, with a start attempt while busy
      r = rows[0]; r.thr = '1;
      p0 = pke_total; d0 = done_total;
      drive_start(r);
      cyc(2);
      for (int k = 0; k < 2; k++) strobe(24'h700000, 1'b1);
      bus.prn_key_in = 10'h3FF; bus.step = 11'd7; bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      for (int k = 0; k < 2; k++) strobe(r.mags[0][k], 1'b1);
      for (int k = 0; k < 2; k++) strobe(24'h700001, 1'b1);
      for (int k = 0; k < 2; k++) strobe(r.mags[1][k], 1'b1);
      strobe(24'h700002, 1'b1);
      chk("busy_before_abort", bus.busy, 1);
      bus.abort = 1'b1;
      cyc(1);
      bus.abort = 1'b0;
      chk("busy_after_abort", bus.busy, 0);
      chk("abort_best_bin", bus.best_bin, 1);
      chk("abort_best_mag", bus.best_mag, 90);
      cyc(5);
      chk("abort_no_done", done_total, d0);
      chk("start_ignored_busy", pke_total, p0 + 1);

      // start together with abort in IDLE: nothing starts
      bus.start = 1'b1; bus.abort = 1'b1;
      cyc(1);
      bus.start = 1'b0; bus.abort = 1'b0;
      chk("start_abort_busy", bus.busy, 0);
      cyc(3);
      chk("start_abort_no_load", pke_total, p0 + 1);

      // Fresh start after abort restarts from bin 0
      run_row(rows[0], 1'b0);

      // Reset in DWELL of bin 3
      r = rows[0]; r.thr = '1;
      drive_start(r);
      cyc(2);
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 2; k++) strobe(24'h700000, 1'b1);
         for (int k = 0; k < 2; k++) strobe(r.mags[b][k], 1'b1);
      end
      for (int k = 0; k < 2; k++) strobe(24'h700003, 1'b1);
      strobe(r.mags[3][0], 1'b1);
      chk("partial_best_bin", bus.best_bin, 1);
      chk("partial_best_mag", bus.best_mag, 90);
      #2 rstn = 1'b0;
      #1;
      chk("mrst_busy", bus.busy, 0);
      chk("mrst_best_bin", bus.best_bin, 0);
      chk("mrst_best_mag", bus.best_mag, 0);
      chk("mrst_prn_key", bus.prn_key, 0);
      chk("mrst_code_slew", bus.code_slew, 0);
      cyc(2);
      rstn = 1'b1;
      cyc(2);
      run_row(rows[2], 1'b0);

      cyc(5);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/code_search_ctrl.md
# code_search_ctrl

Acquisition search sequencer for one tracking channel. Loads a PRN into the C/A code generator, then steps the replica code phase through a programmed number of bins by issuing half-chip slews. In each bin it accumulates correlation magnitudes over a dwell of several dumps and keeps the bin with the largest accumulated magnitude. It sits between the channel's software register block and the code generator / correlator accumulators.

## Interface
Parameters:
- BIN_W, 11, width of bin count and bin index
- DWELL_W, 8, width of dwell count (dumps per bin)
- MAG_W, 24, width of per-dump correlation magnitude

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins a search (ignored while busy)
- abort  in  1  single-cycle pulse; terminates a search
- prn_key_in  in  10  G2 initial state for the search PRN
- step  in  11  half-chips slewed between bins
- num_bins  in  BIN_W  bins to search
- dwell  in  DWELL_W  magnitude results accumulated per bin
- threshold  in  MAG_W+DWELL_W  early-exit threshold (used only with the macro)
- mag_valid  in  1  single-cycle strobe, one per correlator dump
- mag  in  MAG_W  unsigned magnitude, valid with mag_valid
- prn_key_enable  out  1  load pulse to code generator
- prn_key  out  10  PRN key to code generator
- slew_enable  out  1  slew request pulse to code generator
- code_slew  out  11  slew amount to code generator
- busy  out  1  search in progress
- done  out  1  single-cycle completion pulse
- hit  out  1  early-exit threshold crossed (sticky until next start)
- best_bin  out  BIN_W  index of best bin
- best_mag  out  MAG_W+DWELL_W  accumulated magnitude of best bin

## Operation
- On start in IDLE: latch prn_key_in→prn_key, step→code_slew, num_bins and dwell (a value of 0 is treated as 1). Clear bin, acc, hit, best_bin and best_mag. Go to LOAD.
- LOAD: prn_key_enable=1 for one cycle; discard counter=2; → DISCARD.
- DISCARD: each mag_valid decrements the discard counter without accumulating; when it reaches 0 → DWELL with acc=0 and dwell_cnt=0.
- DWELL: each mag_valid adds mag to acc (width MAG_W+DWELL_W, cannot overflow) and increments dwell_cnt. When dwell_cnt reaches dwell → EVAL.
- EVAL: update best if bin==0 or acc>best_mag (strictly greater; ties keep the earlier bin).
  - If bin==num_bins-1 → DONE.
  - Otherwise → SLEW.
- SLEW: slew_enable=1 for one cycle; bin increments; discard counter=2; → DISCARD.
  - The two discarded results cover the partial dump and the extended slewed dump.
- DONE: done=1 for one cycle; → IDLE.
- mag_valid in IDLE, LOAD, EVAL, SLEW or DONE is ignored and not counted.
- abort in any non-IDLE state → IDLE next cycle.
  - No done pulse.
  - best_bin and best_mag hold partial results.
  - abort takes priority over every other transition, including mag_valid in the same cycle.
- start while busy: ignored. start and abort together in IDLE: abort wins and no search starts.

## Timing
- Reset value of every output and register is 0. State after reset is IDLE.
- busy is 1 from the cycle after start is accepted up to and including the DONE cycle. It is 0 the cycle after DONE or after abort.
- prn_key_enable is asserted the cycle after start; prn_key is valid in that same cycle.
- An EVAL result (best_bin, best_mag) is visible the cycle after EVAL. In the DONE cycle, the final result is stable.
- slew_enable is asserted the cycle after EVAL. code_slew is constant for the whole search.
- A search with N bins and dwell D consumes exactly N*(D+2) counted mag_valid strobes.

## Configuration
- CODE_SEARCH_EARLY_EXIT_EN defined:
  - In EVAL, if acc>threshold: set hit=1, record this bin as best, → DONE, skipping the remaining bins.
- Not defined:
  - threshold is ignored and hit is tied to 0.
  - All num_bins bins are always searched.

## Test plan
- Reset mid-search (in DWELL, after 3 bins): deassert rstn → all outputs 0 immediately, IDLE. The next start runs normally.
- Basic search, num_bins=4, dwell=2, step=2:
  - Mag per bin after discards: bin0 {10,10}, bin1 {50,40}, bin2 {30,30}, bin3 {5,5}.
  - Expect one prn_key_enable, three slew_enable pulses with code_slew=2, done after the 16th strobe.
  - Expect best_bin=1, best_mag=90.
- Tie and degenerate values: num_bins=0, dwell=0 → one bin, one result after 2 discards, done. Then num_bins=2 with equal sums → best_bin=0.
- Abort in DISCARD of bin 2 → busy drops the next cycle with no done pulse and best_bin holds its prior value. start is ignored while busy, and a later start restarts from bin 0.
- Ignored strobes: mag_valid pulses in IDLE and in EVAL do not alter acc or any counter. The total counted strobes still equal N*(D+2).
- With CODE_SEARCH_EARLY_EXIT_EN, threshold=60 and the stimulus from the basic search → done after bin1, hit=1, best_bin=1, exactly one slew_enable. Without the macro → full 4-bin search and hit=0.
